// File: rtl/sprite_line_engine.sv
// Per-line sprite evaluator and 2-stage compositor: scans OAM for the next line,
// fetches pattern rows into a shadow slot set, then swaps it atomically into the pixel path.
module sprite_line_engine #(
    parameter int NUM_SPRITES = 8,
    parameter int PIPE_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [8:0]  line_y,
    output logic        eval_busy,
    output logic        pat_en,
    output logic [11:0] pat_addr,
    input  logic [7:0]  pat_rdata,
    input  logic        cfg_we,
    input  logic [5:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        in_valid,
    input  logic [8:0]  in_x,
    input  logic [15:0] in_color,
    output logic        out_valid,
    output logic [15:0] out_color
);

    localparam int unused_lat = PIPE_LAT;
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_wdata[15:10];

    typedef enum logic [2:0] {IDLE, CHECK, FETCH_LO, FETCH_HI, STORE, COMMIT} state_t;

    function automatic logic [1:0] pixel_index(input logic [15:0] row, input logic [2:0] col);
        return 2'(row >> {~col, 1'b0});
    endfunction

    logic [NUM_SPRITES-1:0] oam_en;
    logic [8:0]  oam_y    [NUM_SPRITES];
    logic [8:0]  oam_x    [NUM_SPRITES];
    logic [1:0]  oam_pal  [NUM_SPRITES];
    logic [7:0]  oam_tile [NUM_SPRITES];
    logic [14:0] pal_mem  [16];

    state_t      state;
    logic [2:0]  idx_q;
    logic [8:0]  ly_q;
    logic [8:0]  cur_x;
    logic [1:0]  cur_pal;
    logic [7:0]  lo_byte;

    logic [NUM_SPRITES-1:0] sh_valid, act_valid;
    logic [8:0]  sh_x   [NUM_SPRITES];
    logic [1:0]  sh_pal [NUM_SPRITES];
    logic [15:0] sh_row [NUM_SPRITES];
    logic [8:0]  act_x   [NUM_SPRITES];
    logic [1:0]  act_pal [NUM_SPRITES];
    logic [15:0] act_row [NUM_SPRITES];

    logic [9:0]  chk_dy;
    logic        chk_hit;
    logic        last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oam_en <= '0;
            for (int i = 0; i < 16; i++) pal_mem[i] <= '0;
        end else if (cfg_we) begin
            if (cfg_addr[5]) pal_mem[cfg_addr[3:0]] <= cfg_wdata[14:0];
            else if (cfg_addr[1:0] == 2'd0) oam_en[cfg_addr[4:2]] <= cfg_wdata[9];
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && !cfg_addr[5]) begin
            case (cfg_addr[1:0])
                2'd0: oam_y[cfg_addr[4:2]] <= cfg_wdata[8:0];
                2'd1: oam_x[cfg_addr[4:2]] <= cfg_wdata[8:0];
                2'd2: begin
                    oam_pal[cfg_addr[4:2]]  <= cfg_wdata[9:8];
                    oam_tile[cfg_addr[4:2]] <= cfg_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    // A negative dy sets bit 9, so "0 <= dy <= 7" reduces to the upper seven bits being zero.
    assign chk_dy   = {1'b0, ly_q} - {1'b0, oam_y[idx_q]};
    assign chk_hit  = oam_en[idx_q] && (chk_dy[9:3] == 7'd0);
    assign last_idx = (idx_q == 3'(NUM_SPRITES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            eval_busy <= 1'b0;
            pat_en    <= 1'b0;
            pat_addr  <= '0;
            idx_q     <= '0;
            ly_q      <= '0;
            cur_x     <= '0;
            cur_pal   <= '0;
            lo_byte   <= '0;
            sh_valid  <= '0;
            act_valid <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]    <= '0;
                sh_pal[i]  <= '0;
                sh_row[i]  <= '0;
                act_x[i]   <= '0;
                act_pal[i] <= '0;
                act_row[i] <= '0;
            end
        end else if (line_start) begin
            // Also the abort path: the shadow set restarts empty, the active set is left alone.
            ly_q      <= line_y;
            idx_q     <= '0;
            sh_valid  <= '0;
            pat_en    <= 1'b0;
            eval_busy <= 1'b1;
            state     <= CHECK;
        end else begin
            case (state)
                CHECK: begin
                    if (chk_hit) begin
                        cur_x    <= oam_x[idx_q];
                        cur_pal  <= oam_pal[idx_q];
                        pat_addr <= {oam_tile[idx_q], chk_dy[2:0], 1'b0};
                        pat_en   <= 1'b1;
                        state    <= FETCH_LO;
                    end else if (last_idx) begin
                        state <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                FETCH_LO: begin
                    pat_addr[0] <= 1'b1;
                    state       <= FETCH_HI;
                end
                FETCH_HI: begin
                    lo_byte <= pat_rdata;
                    pat_en  <= 1'b0;
                    state   <= STORE;
                end
                STORE: begin
                    sh_valid[idx_q] <= 1'b1;
                    sh_x[idx_q]     <= cur_x;
                    sh_pal[idx_q]   <= cur_pal;
                    sh_row[idx_q]   <= {lo_byte, pat_rdata};
                    if (last_idx) begin
                        state <= COMMIT;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                        state <= CHECK;
                    end
                end
                COMMIT: begin
                    act_valid <= sh_valid;
                    act_x     <= sh_x;
                    act_pal   <= sh_pal;
                    act_row   <= sh_row;
                    eval_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: register the background pixel
    logic        vld_p1;
    logic [8:0]  x_p1;
    logic [15:0] color_p1;

    always_ff @(posedge clk) begin
        x_p1     <= in_x;
        color_p1 <= in_color;
    end

    logic [9:0] dx  [NUM_SPRITES];
    logic [1:0] pix [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] slot_hit;

    for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_slot
        assign dx[s]       = {1'b0, x_p1} - {1'b0, act_x[s]};
        assign pix[s]      = pixel_index(act_row[s], dx[s][2:0]);
        assign slot_hit[s] = act_valid[s] && (dx[s][9:3] == 7'd0) && (pix[s] != 2'd0);
    end

    logic       win_hit;
    logic [1:0] win_pal;
    logic [1:0] win_idx;

    always_comb begin
        win_hit = 1'b0;
        win_pal = '0;
        win_idx = '0;
        for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
            if (slot_hit[s]) begin
                win_hit = 1'b1;
                win_pal = act_pal[s];
                win_idx = pix[s];
            end
        end
    end

    // Stage 2: priority-resolved sprite colour or background
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_color <= '0;
        end else begin
            vld_p1    <= in_valid;
            out_valid <= vld_p1;
            if (vld_p1) out_color <= win_hit ? {1'b0, pal_mem[{win_pal, win_idx}]} : color_p1;
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: evaluation timing, pattern fetch addresses,
// compositing priority, abort and reset behaviour.
module tb_sprite_line_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [8:0]  line_y = '0;
    logic        eval_busy;
    logic        pat_en;
    logic [11:0] pat_addr;
    logic [7:0]  pat_rdata = '0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_x = '0;
    logic [15:0] in_color = '0;
    logic        out_valid;
    logic [15:0] out_color;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] pat_mem [4096];

    sprite_line_engine dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y),
        .eval_busy(eval_busy), .pat_en(pat_en), .pat_addr(pat_addr), .pat_rdata(pat_rdata),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_x(in_x), .in_color(in_color),
        .out_valid(out_valid), .out_color(out_color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pat_en) pat_rdata <= pat_mem[pat_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic oam_write(input logic [2:0] s, input logic en, input logic [8:0] y,
                             input logic [8:0] x, input logic [1:0] pal, input logic [7:0] tile);
        cfg_write({1'b0, s, 2'd0}, {6'd0, en, y});
        cfg_write({1'b0, s, 2'd1}, {7'd0, x});
        cfg_write({1'b0, s, 2'd2}, {6'd0, pal, tile});
    endtask

    task automatic pal_write(input logic [1:0] p, input logic [1:0] i, input logic [15:0] c);
        cfg_write({2'b10, p, i}, c);
    endtask

    task automatic start_line(input logic [8:0] ly);
        line_y = ly;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic run_line(input logic [8:0] ly, output int busy_n, output int reads,
                            output logic [11:0] first_a, output logic [11:0] second_a,
                            output logic [11:0] last_a);
        start_line(ly);
        busy_n = 0;
        reads = 0;
        first_a = '0;
        second_a = '0;
        last_a = '0;
        while (eval_busy === 1'b1 && busy_n < 200) begin
            if (pat_en === 1'b1) begin
                if (reads == 0) first_a = pat_addr;
                if (reads == 1) second_a = pat_addr;
                last_a = pat_addr;
                reads++;
            end
            busy_n++;
            tick();
        end
    endtask

    task automatic send_pixel(input logic [8:0] x, input logic [15:0] c,
                              output logic early_v, output logic v, output logic [15:0] oc);
        in_valid = 1'b1;
        in_x = x;
        in_color = c;
        tick();
        early_v = out_valid;
        in_valid = 1'b0;
        tick();
        v = out_valid;
        oc = out_color;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (eval_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", eval_busy); end
        vectors++; if (pat_en !== 1'b0) begin miscompares++; $display("FAIL reset_pat_en got %b want 0", pat_en); end
        vectors++; if (pat_addr !== 12'h000) begin miscompares++; $display("FAIL reset_pat_addr got %h want 000", pat_addr); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (out_color !== 16'h0000) begin miscompares++; $display("FAIL reset_out_color got %h want 0000", out_color); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_hit();
        int n, r;
        logic [11:0] a0, a1, al;
        logic ev, v;
        logic [15:0] oc;
        pat_mem[12'h034] = 8'h1B;
        pat_mem[12'h035] = 8'h00;
        oam_write(3'd0, 1'b1, 9'd10, 9'd20, 2'd1, 8'd3);
        pal_write(2'd1, 2'd0, 16'h1234);
        pal_write(2'd1, 2'd1, 16'h7C00);
        pal_write(2'd1, 2'd2, 16'h03E0);
        pal_write(2'd1, 2'd3, 16'h001F);
        run_line(9'd12, n, r, a0, a1, al);
        vectors++; if (n != 12) begin miscompares++; $display("FAIL single_busy_cycles got %0d want 12", n); end
        vectors++; if (r != 2) begin miscompares++; $display("FAIL single_reads got %0d want 2", r); end
        vectors++; if (a0 !== 12'h034) begin miscompares++; $display("FAIL single_addr_lo got %h want 034", a0); end
        vectors++; if (a1 !== 12'h035) begin miscompares++; $display("FAIL single_addr_hi got %h want 035", a1); end
        send_pixel(9'd20, 16'h8000, ev, v, oc);
        vectors++; if (ev !== 1'b0) begin miscompares++; $display("FAIL single_latency_early got %b want 0", ev); end
        vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL single_latency_valid got %b want 1", v); end
        vectors++; if (oc !== 16'h8000) begin miscompares++; $display("FAIL single_x20 got %h want 8000", oc); end
        send_pixel(9'd21, 16'h0111, ev, v, oc);
        vectors++; if (oc !== 16'h7C00) begin miscompares++; $display("FAIL single_x21 got %h want 7c00", oc); end
        send_pixel(9'd22, 16'h0111, ev, v, oc);
        vectors++; if (oc !== 16'h03E0) begin miscompares++; $display("FAIL single_x22 got %h want 03e0", oc); end
        send_pixel(9'd23, 16'h0111, ev, v, oc);
        vectors++; if (oc !== 16'h001F) begin miscompares++; $display("FAIL single_x23 got %h want 001f", oc); end
        send_pixel(9'd24, 16'h0222, ev, v, oc);
        vectors++; if (oc !== 16'h0222) begin miscompares++; $display("FAIL single_x24 got %h want 0222", oc); end
        send_pixel(9'd19, 16'h0333, ev, v, oc);
        vectors++; if (oc !== 16'h0333) begin miscompares++; $display("FAIL single_x19 got %h want 0333", oc); end
        tick();
        vectors++; if (out_color !== 16'h0333) begin miscompares++; $display("FAIL single_hold got %h want 0333", out_color); end
    endtask

    task automatic test_all_eight();
        int n, r;
        logic [11:0] a0, a1, al;
        for (int s = 0; s < 8; s++) oam_write(3'(s), 1'b1, 9'd0, 9'(200 + 10 * s), 2'd0, 8'(16 + s));
        run_line(9'd0, n, r, a0, a1, al);
        vectors++; if (n != 33) begin miscompares++; $display("FAIL eight_busy_cycles got %0d want 33", n); end
        vectors++; if (r != 16) begin miscompares++; $display("FAIL eight_reads got %0d want 16", r); end
        vectors++; if (a0 !== 12'h100) begin miscompares++; $display("FAIL eight_first_addr got %h want 100", a0); end
        vectors++; if (al !== 12'h171) begin miscompares++; $display("FAIL eight_last_addr got %h want 171", al); end
    endtask

    task automatic test_overlap();
        int n, r;
        logic [11:0] a0, a1, al;
        logic ev, v;
        logic [15:0] oc;
        apply_reset();
        pat_mem[12'h100] = 8'h40;
        pat_mem[12'h101] = 8'h00;
        pat_mem[12'h110] = 8'h3F;
        pat_mem[12'h111] = 8'h00;
        oam_write(3'd2, 1'b1, 9'd50, 9'd100, 2'd2, 8'h10);
        oam_write(3'd5, 1'b1, 9'd50, 9'd98, 2'd3, 8'h11);
        pal_write(2'd2, 2'd1, 16'h0AAA);
        pal_write(2'd3, 2'd3, 16'h0555);
        run_line(9'd50, n, r, a0, a1, al);
        vectors++; if (n != 15) begin miscompares++; $display("FAIL overlap_busy_cycles got %0d want 15", n); end
        vectors++; if (al !== 12'h111) begin miscompares++; $display("FAIL overlap_last_addr got %h want 111", al); end
        send_pixel(9'd100, 16'h0001, ev, v, oc);
        vectors++; if (oc !== 16'h0AAA) begin miscompares++; $display("FAIL overlap_x100 got %h want 0aaa", oc); end
        send_pixel(9'd101, 16'h0002, ev, v, oc);
        vectors++; if (oc !== 16'h0555) begin miscompares++; $display("FAIL overlap_x101 got %h want 0555", oc); end
        send_pixel(9'd98, 16'h0003, ev, v, oc);
        vectors++; if (oc !== 16'h0003) begin miscompares++; $display("FAIL overlap_x98 got %h want 0003", oc); end
        send_pixel(9'd99, 16'h0004, ev, v, oc);
        vectors++; if (oc !== 16'h0555) begin miscompares++; $display("FAIL overlap_x99 got %h want 0555", oc); end
    endtask

    task automatic test_miss_and_edge();
        int n, r;
        logic [11:0] a0, a1, al;
        logic ev, v;
        logic [15:0] oc;
        apply_reset();
        pat_mem[12'h05E] = 8'h55;
        pat_mem[12'h05F] = 8'h55;
        oam_write(3'd0, 1'b1, 9'd10, 9'd508, 2'd1, 8'd5);
        pal_write(2'd1, 2'd1, 16'h2222);
        run_line(9'd9, n, r, a0, a1, al);
        vectors++; if (n != 9) begin miscompares++; $display("FAIL miss_busy_cycles got %0d want 9", n); end
        vectors++; if (r != 0) begin miscompares++; $display("FAIL miss_reads got %0d want 0", r); end
        cfg_write(6'b000000, {6'd0, 1'b1, 9'd2});
        run_line(9'd9, n, r, a0, a1, al);
        vectors++; if (n != 12) begin miscompares++; $display("FAIL dy7_busy_cycles got %0d want 12", n); end
        vectors++; if (a0 !== 12'h05E) begin miscompares++; $display("FAIL dy7_addr_lo got %h want 05e", a0); end
        vectors++; if (a1 !== 12'h05F) begin miscompares++; $display("FAIL dy7_addr_hi got %h want 05f", a1); end
        send_pixel(9'd511, 16'h0100, ev, v, oc);
        vectors++; if (oc !== 16'h2222) begin miscompares++; $display("FAIL edge_x511 got %h want 2222", oc); end
        send_pixel(9'd0, 16'h0101, ev, v, oc);
        vectors++; if (oc !== 16'h0101) begin miscompares++; $display("FAIL edge_x0_nowrap got %h want 0101", oc); end
        send_pixel(9'd507, 16'h0102, ev, v, oc);
        vectors++; if (oc !== 16'h0102) begin miscompares++; $display("FAIL edge_x507 got %h want 0102", oc); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic ev, v;
        logic [15:0] oc;
        oam_write(3'd0, 1'b1, 9'd2, 9'd100, 2'd1, 8'd5);
        start_line(9'd9);
        tick();
        vectors++; if (pat_en !== 1'b1 || pat_addr !== 12'h05E) begin miscompares++; $display("FAIL b2b_first_fetch got en=%b addr=%h want en=1 addr=05e", pat_en, pat_addr); end
        start_line(9'd9);
        vectors++; if (pat_en !== 1'b0 || eval_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_abort got en=%b busy=%b want en=0 busy=1", pat_en, eval_busy); end
        tick();
        vectors++; if (pat_en !== 1'b1 || pat_addr !== 12'h05E) begin miscompares++; $display("FAIL b2b_restart_fetch got en=%b addr=%h want en=1 addr=05e", pat_en, pat_addr); end
        send_pixel(9'd510, 16'h0300, ev, v, oc);
        vectors++; if (oc !== 16'h2222) begin miscompares++; $display("FAIL b2b_old_set got %h want 2222", oc); end
        vectors++; if (eval_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_still_busy got %b want 1", eval_busy); end
        n = 0;
        while (eval_busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        vectors++; if (n != 9) begin miscompares++; $display("FAIL b2b_commit_wait got %0d want 9", n); end
        send_pixel(9'd510, 16'h0300, ev, v, oc);
        vectors++; if (oc !== 16'h0300) begin miscompares++; $display("FAIL b2b_new_set_x510 got %h want 0300", oc); end
        send_pixel(9'd100, 16'h0301, ev, v, oc);
        vectors++; if (oc !== 16'h2222) begin miscompares++; $display("FAIL b2b_new_set_x100 got %h want 2222", oc); end
    endtask

    task automatic test_reset_mid();
        logic ev, v;
        logic [15:0] oc;
        start_line(9'd9);
        tick();
        tick();
        vectors++; if (pat_en !== 1'b1 || pat_addr !== 12'h05F) begin miscompares++; $display("FAIL rstmid_fetch_hi got en=%b addr=%h want en=1 addr=05f", pat_en, pat_addr); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (pat_en !== 1'b0 || eval_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_async got en=%b busy=%b want 0 0", pat_en, eval_busy); end
        tick();
        rst = 1'b0;
        tick();
        send_pixel(9'd100, 16'h0ABC, ev, v, oc);
        vectors++; if (oc !== 16'h0ABC) begin miscompares++; $display("FAIL rstmid_pass_x100 got %h want 0abc", oc); end
        send_pixel(9'd510, 16'h8123, ev, v, oc);
        vectors++; if (oc !== 16'h8123) begin miscompares++; $display("FAIL rstmid_pass_x510 got %h want 8123", oc); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) pat_mem[i] = 8'h00;
        test_reset();
        test_single_hit();
        test_all_eight();
        test_overlap();
        test_miss_and_edge();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
